serial_hex_display: RTL and testbench



---
 rtl/serial_hex_display_pkg.sv | 49 ++++
 rtl/serial_hex_display_uart_rx.sv | 135 +++++++++++++
 rtl/serial_hex_display.sv | 150 +++++++++++++++
 tb/tb_serial_hex_display.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_hex_display_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_hex_display_pkg
//  Description : Shared types for the serial hex display: receiver state
//                encoding, byte-buffer entry layout and the hex-digit to
//                active-low seven-segment encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_hex_display_pkg;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef struct packed {
        logic       valid;
        logic       ferr;
        logic [7:0] data;
    } byte_entry_t;

    // Segments a..g on bits 0..6, active-low; lowercase b and d.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage : serial_hex_display_pkg
`default_nettype wire

// File: rtl/serial_hex_display_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : 8N1 UART receiver with 2-flop input synchroniser. Samples
//                the start bit at half a bit period, then every bit period.
//                The byte is always delivered after the stop sample; a low
//                stop sample flags a framing error.
//  Ports       : CLK, RESET (sync, active-low), ENABLE (clock enable),
//                RX (async line, idle high) -> data[7:0], ferr,
//                valid (one-cycle strobe accompanying data/ferr).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import serial_hex_display_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE,
    input  logic       RX,
    output logic [7:0] data,
    output logic       ferr,
    output logic       valid
);

    localparam int c_bit_cycles  = CLK_FREQ / BAUD;
    localparam int c_half_cycles = c_bit_cycles / 2;
    localparam int c_cnt_w       = $clog2(c_bit_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(c_bit_cycles - 1);
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(c_half_cycles - 1);

    logic               r_sync1;
    logic               r_sync2;
    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_armed;
    logic [7:0]         r_data;
    logic               r_ferr;
    logic               r_valid;

    logic               w_cnt_clr;
    logic               w_sample;
    logic               w_deliver;

    always_comb begin
        w_state_next = r_state;
        w_cnt_clr    = 1'b0;
        w_sample     = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_clr = 1'b1;
                // Only a falling line after a seen high starts a frame, so a
                // line still low after reset or a break cannot start one.
                if (r_armed && !r_sync2) begin
                    w_state_next = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == c_half_last) begin
                    w_cnt_clr    = 1'b1;
                    w_state_next = r_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr = 1'b1;
                    w_sample  = 1'b1;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == c_bit_last) begin
                    w_cnt_clr    = 1'b1;
                    w_deliver    = 1'b1;
                    w_state_next = RX_IDLE;
                end
            end
            default: begin
                w_state_next = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            // Synchroniser clears low so the line must be observed high
            // before the receiver arms.
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'h00;
            r_armed   <= 1'b0;
            r_data    <= 8'h00;
            r_ferr    <= 1'b0;
            r_valid   <= 1'b0;
        end else if (ENABLE) begin
            r_sync1 <= RX;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_clr ? '0 : r_cnt + 1'b1;
            r_valid <= w_deliver;
            if (r_state == RX_IDLE) begin
                r_bit_idx <= 3'd0;
                if (r_sync2) begin
                    r_armed <= 1'b1;
                end
            end
            if (w_sample) begin
                r_shift   <= {r_sync2, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_deliver) begin
                r_data  <= r_shift;
                r_ferr  <= !r_sync2;
                r_armed <= 1'b0;
            end
        end
    end

    assign data  = r_data;
    assign ferr  = r_ferr;
    assign valid = r_valid;

endmodule : uart_rx
`default_nettype wire

// File: rtl/serial_hex_display.sv
`default_nettype none
// ============================================================================
//  Module      : serial_hex_display
//  Description : Receives UART bytes and shows the most recent DIGITS/2 of
//                them as hex pairs on a multiplexed active-low 7-segment
//                display. Entry k drives digits 2k (low nibble) and 2k+1
//                (high nibble); the DP of digit 2k marks a framing error.
//                Never-written digits are blank.
//  Ports       : CLK, RESET (sync, active-low), ENABLE (clock enable),
//                RX (UART line) -> SS_AN[DIGITS-1:0] (anodes, active-low,
//                bit 0 rightmost), SS_SEG[6:0] (a..g, active-low),
//                SS_DP (decimal point, active-low).
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_hex_display
    import serial_hex_display_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int DIGITS       = 8,
    parameter int DIGIT_CYCLES = 100_000
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic              RX,
    output logic [DIGITS-1:0] SS_AN,
    output logic [6:0]        SS_SEG,
    output logic              SS_DP
);

    localparam int c_entries = DIGITS / 2;
    localparam int c_dig_w   = $clog2(DIGITS);
    localparam int c_cyc_w   = $clog2(DIGIT_CYCLES);
    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(DIGIT_CYCLES - 1);
    localparam logic [c_dig_w-1:0] c_dig_last = c_dig_w'(DIGITS - 1);

    logic [7:0]         w_rx_data;
    logic               w_rx_ferr;
    logic               w_rx_valid;

    byte_entry_t        r_buf [c_entries];
    logic [c_cyc_w-1:0] r_cyc;
    logic [c_dig_w-1:0] r_digit;
    logic               r_started;

    byte_entry_t        w_entry;
    logic [3:0]         w_nibble;
    logic [DIGITS-1:0]  w_an_next;
    logic [6:0]         w_seg_next;
    logic               w_dp_next;

    logic [DIGITS-1:0]  r_an;
    logic [6:0]         r_seg;
    logic               r_dp;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_uart_rx (
        .CLK    (CLK),
        .RESET  (RESET),
        .ENABLE (ENABLE),
        .RX     (RX),
        .data   (w_rx_data),
        .ferr   (w_rx_ferr),
        .valid  (w_rx_valid)
    );

    // Byte history: new byte enters entry 0, oldest falls off the top.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int k = 0; k < c_entries; k++) begin
                r_buf[k] <= '0;
            end
        end else if (ENABLE && w_rx_valid) begin
            for (int k = c_entries - 1; k > 0; k--) begin
                r_buf[k] <= r_buf[k-1];
            end
            r_buf[0] <= '{valid: 1'b1, ferr: w_rx_ferr, data: w_rx_data};
        end
    end

    // Refresh timing. The first wrap only lights digit 0; later wraps step
    // the digit index, so every slot (including the first) is full length.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_cyc     <= '0;
            r_digit   <= '0;
            r_started <= 1'b0;
        end else if (ENABLE) begin
            if (r_cyc == c_cyc_last) begin
                r_cyc <= '0;
                if (!r_started) begin
                    r_started <= 1'b1;
                end else if (r_digit == c_dig_last) begin
                    r_digit <= '0;
                end else begin
                    r_digit <= r_digit + 1'b1;
                end
            end else begin
                r_cyc <= r_cyc + 1'b1;
            end
        end
    end

    always_comb begin
        w_entry = r_buf[0];
        for (int k = 0; k < c_entries; k++) begin
            if (k == int'(r_digit >> 1)) begin
                w_entry = r_buf[k];
            end
        end
        w_nibble   = r_digit[0] ? w_entry.data[7:4] : w_entry.data[3:0];
        w_an_next  = '1;
        w_seg_next = 7'h7F;
        w_dp_next  = 1'b1;
        if (r_started) begin
            for (int k = 0; k < DIGITS; k++) begin
                if (k == int'(r_digit)) begin
                    w_an_next[k] = 1'b0;
                end
            end
            if (w_entry.valid) begin
                w_seg_next = hex_to_seg(w_nibble);
                w_dp_next  = !(w_entry.ferr && !r_digit[0]);
            end
        end
    end

    // Anode, segments and DP are registered together, so a digit change
    // never shows the previous digit's segments on the new anode.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_an  <= '1;
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
        end else if (ENABLE) begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
            r_dp  <= w_dp_next;
        end
    end

    assign SS_AN  = r_an;
    assign SS_SEG = r_seg;
    assign SS_DP  = r_dp;

endmodule : serial_hex_display
`default_nettype wire

// File: tb/tb_serial_hex_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_hex_display
//  Description : Self-checking bench for serial_hex_display. Sent bytes are
//                queued as expected entries, folded into a reference byte
//                history and compared against each multiplexed digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_hex_display;

    localparam int CLK_FREQ     = 1_000_000;
    localparam int BAUD         = 100_000;
    localparam int DIGITS       = 4;
    localparam int DIGIT_CYCLES = 4;
    localparam int BIT          = CLK_FREQ / BAUD;

    typedef struct packed {
        logic       valid;
        logic       ferr;
        logic [7:0] data;
    } ent_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       enable = 1'b1;
    logic       rx     = 1'b1;
    logic [3:0] ss_an;
    logic [6:0] ss_seg;
    logic       ss_dp;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t model [2];
    ent_t sb_q [$];

    always #5 clk = ~clk;

    serial_hex_display #(
        .CLK_FREQ     (CLK_FREQ),
        .BAUD         (BAUD),
        .DIGITS       (DIGITS),
        .DIGIT_CYCLES (DIGIT_CYCLES)
    ) dut (
        .CLK    (clk),
        .RESET  (rst_n),
        .ENABLE (enable),
        .RX     (rx),
        .SS_AN  (ss_an),
        .SS_SEG (ss_seg),
        .SS_DP  (ss_dp)
    );

    function automatic logic [6:0] exp_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    task automatic clear_model;
        model[0] = '0;
        model[1] = '0;
        sb_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        sb_q.push_back('{valid: 1'b1, ferr: !stop_bit, data: b});
        @(negedge clk);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx = stop_bit;
        repeat (BIT) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT) @(negedge clk);
    endtask

    task automatic apply_scoreboard;
        ent_t e;
        while (sb_q.size() > 0) begin
            e        = sb_q.pop_front();
            model[1] = model[0];
            model[0] = e;
        end
    endtask

    // Wait for each digit's slot and compare segments/DP with the model.
    task automatic scan_display(input string name);
        logic [3:0] want_an;
        logic [6:0] want_seg;
        logic       want_dp;
        logic [3:0] nib;
        ent_t       e;
        int         guard;
        for (int d = 0; d < DIGITS; d++) begin
            want_an = 4'b0001 << d;
            want_an = ~want_an;
            e       = model[d / 2];
            nib     = (d % 2 == 1) ? e.data[7:4] : e.data[3:0];
            want_seg = e.valid ? exp_seg(nib) : 7'h7F;
            want_dp  = e.valid ? !(e.ferr && (d % 2 == 0)) : 1'b1;
            guard = 0;
            while (ss_an !== want_an && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            n_cmp++;
            if (ss_an !== want_an) begin
                n_err++;
                $display("FAIL %s digit%0d anode: got %b required %b", name, d, ss_an, want_an);
            end else begin
                n_cmp++;
                if (ss_seg !== want_seg) begin
                    n_err++;
                    $display("FAIL %s digit%0d seg: got %h required %h", name, d, ss_seg, want_seg);
                end
                n_cmp++;
                if (ss_dp !== want_dp) begin
                    n_err++;
                    $display("FAIL %s digit%0d dp: got %b required %b", name, d, ss_dp, want_dp);
                end
            end
        end
    endtask

    task automatic test_reset_refresh;
        int         guard;
        int         p;
        logic [3:0] want_an;
        logic       en_next;
        rst_n  = 1'b0;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        clear_model();
        n_cmp++;
        if (ss_an !== 4'hF) begin
            n_err++;
            $display("FAIL reset_an: got %b required 1111", ss_an);
        end
        n_cmp++;
        if (ss_seg !== 7'h7F) begin
            n_err++;
            $display("FAIL reset_seg: got %h required 7f", ss_seg);
        end
        n_cmp++;
        if (ss_dp !== 1'b1) begin
            n_err++;
            $display("FAIL reset_dp: got %b required 1", ss_dp);
        end
        rst_n = 1'b1;
        guard = 0;
        while (ss_an === 4'hF && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard != 5) begin
            n_err++;
            $display("FAIL first_anode_latency: got %0d cycles required 5", guard);
        end
        // Walk the refresh sequence, pausing it with ENABLE low mid-slot.
        p = 0;
        for (int c = 0; c < 32; c++) begin
            want_an = 4'b0001 << ((p / DIGIT_CYCLES) % DIGITS);
            want_an = ~want_an;
            n_cmp++;
            if (ss_an !== want_an || ss_seg !== 7'h7F || ss_dp !== 1'b1) begin
                n_err++;
                $display("FAIL refresh c=%0d: got an=%b seg=%h dp=%b required an=%b seg=7f dp=1",
                         c, ss_an, ss_seg, ss_dp, want_an);
            end
            en_next = !(c >= 5 && c < 13);
            enable  = en_next;
            @(negedge clk);
            if (en_next) p++;
        end
        enable = 1'b1;
    endtask

    task automatic test_single_byte;
        send_byte(8'hA5, 1'b1);
        apply_scoreboard();
        scan_display("single_a5");
    endtask

    task automatic test_back_to_back;
        send_byte(8'h3C, 1'b1);
        send_byte(8'h7E, 1'b1);
        apply_scoreboard();
        scan_display("pair_3c7e");
        send_byte(8'h01, 1'b1);
        apply_scoreboard();
        scan_display("shift_01");
    endtask

    task automatic test_framing_error;
        send_byte(8'h42, 1'b0);
        apply_scoreboard();
        scan_display("ferr_42");
    endtask

    task automatic test_glitch;
        @(negedge clk);
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        scan_display("glitch");
    endtask

    task automatic test_reset_mid_byte;
        @(negedge clk);
        rx = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        // Remaining data bits of 0x00 and a low stop bit keep the line low.
        repeat (5 * BIT) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        scan_display("post_reset_blank");
        send_byte(8'h99, 1'b1);
        apply_scoreboard();
        scan_display("after_reset_99");
    endtask

    initial begin
        test_reset_refresh();
        test_single_byte();
        test_back_to_back();
        test_framing_error();
        test_glitch();
        test_reset_mid_byte();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_hex_display
`default_nettype wire
